// File: rtl/compute_sequencer.sv
// Job sequencer for a weight-load / accumulate / drain compute engine.
// Optional COMPUTE watchdog enabled by defining SEQ_TIMEOUT_EN.
`timescale 1ns/1ps
module compute_sequencer #(
    parameter int NUM_W   = 4,
    parameter int NUM_ACC = 2,
    parameter int TIMEOUT = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] base_addr,
    input  logic       acc_full,
    input  logic       mem_ready,
    output logic       busy,
    output logic       done,
    output logic       acc_clear,
    output logic       load_w,
    output logic [3:0] w_idx,
    output logic       acc_valid,
    output logic       mem_we,
    output logic [7:0] mem_addr,
    output logic [1:0] acc_sel,
    output logic       timeout_err
);

    generate
        if (NUM_W < 1 || NUM_W > 15 || NUM_ACC < 1 || NUM_ACC > 4 ||
            TIMEOUT < 2 || TIMEOUT > 255) begin : g_bad_param
            $error("compute_sequencer: parameter out of range");
        end
    endgenerate

    typedef enum logic [2:0] {
        IDLE, CLEAR, LOAD_W, COMPUTE, SETTLE, WRITE, DONE
    } state_t;

    localparam logic [3:0] W_LAST = 4'(NUM_W - 1);
    localparam logic [3:0] A_LAST = 4'(NUM_ACC - 1);

    state_t     state_q, state_d;
    logic [3:0] idx_q, idx_d;   // weight index in LOAD_W, write index in WRITE
    logic [7:0] base_q, base_d;

`ifdef SEQ_TIMEOUT_EN
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);
    logic [7:0] to_cnt_q, to_cnt_d;
    logic       err_q, err_d;
`endif

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        base_d   = base_q;
`ifdef SEQ_TIMEOUT_EN
        to_cnt_d = to_cnt_q;
        err_d    = err_q;
`endif
        case (state_q)
            IDLE: if (start) begin
                state_d = CLEAR;
                base_d  = base_addr;
                idx_d   = '0;
`ifdef SEQ_TIMEOUT_EN
                err_d   = 1'b0;
`endif
            end
            CLEAR: begin
                state_d = LOAD_W;
                idx_d   = '0;
            end
            LOAD_W: begin
                if (idx_q == W_LAST) begin
                    state_d = COMPUTE;
                    idx_d   = '0;
`ifdef SEQ_TIMEOUT_EN
                    to_cnt_d = '0;
`endif
                end else begin
                    idx_d = idx_q + 4'd1;
                end
            end
            COMPUTE: begin
                // acc_full on the last allowed cycle still counts as success
                if (acc_full) begin
                    state_d = SETTLE;
`ifdef SEQ_TIMEOUT_EN
                end else if (to_cnt_q == TO_LAST) begin
                    state_d = DONE;
                    err_d   = 1'b1;
                end else begin
                    to_cnt_d = to_cnt_q + 8'd1;
`endif
                end
            end
            SETTLE: begin
                state_d = WRITE;
                idx_d   = '0;
            end
            WRITE: if (mem_ready) begin
                if (idx_q == A_LAST) begin
                    state_d = DONE;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + 4'd1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            base_q   <= '0;
`ifdef SEQ_TIMEOUT_EN
            to_cnt_q <= '0;
            err_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            base_q   <= base_d;
`ifdef SEQ_TIMEOUT_EN
            to_cnt_q <= to_cnt_d;
            err_q    <= err_d;
`endif
        end
    end

    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign acc_clear = (state_q == CLEAR);
    assign load_w    = (state_q == LOAD_W);
    assign w_idx     = (state_q == LOAD_W) ? idx_q : 4'd0;
    assign acc_valid = (state_q == COMPUTE);
    assign mem_we    = (state_q == WRITE);
    assign mem_addr  = (state_q == WRITE) ? (base_q + {4'd0, idx_q}) : 8'd0;
    assign acc_sel   = (state_q == WRITE) ? idx_q[1:0] : 2'd0;
`ifdef SEQ_TIMEOUT_EN
    assign timeout_err = err_q;
`else
    assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_compute_sequencer.sv
// Scoreboard bench for compute_sequencer: stimulus queues expected events,
// a negedge monitor pops and compares them as the DUT produces them.
`timescale 1ns/1ps
module tb_compute_sequencer;

`ifdef SEQ_TIMEOUT_EN
    localparam int TIMEOUT_P = 8;
`else
    localparam int TIMEOUT_P = 64;
`endif
    localparam int NUM_ACC_P = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [7:0] base_addr = 8'd0;
    logic       acc_full = 1'b0;
    logic       mem_ready = 1'b1;
    logic       busy, done, acc_clear, load_w, acc_valid, mem_we, timeout_err;
    logic [3:0] w_idx;
    logic [7:0] mem_addr;
    logic [1:0] acc_sel;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int t0 = 0;
    logic [31:0] exp_q[$];

    compute_sequencer #(.NUM_W(4), .NUM_ACC(NUM_ACC_P), .TIMEOUT(TIMEOUT_P)) dut (
        .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
        .acc_full(acc_full), .mem_ready(mem_ready), .busy(busy), .done(done),
        .acc_clear(acc_clear), .load_w(load_w), .w_idx(w_idx),
        .acc_valid(acc_valid), .mem_we(mem_we), .mem_addr(mem_addr),
        .acc_sel(acc_sel), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // event encoding: kind 0=clear 1=load_w 2=write 3=done; data; cycle offset from start edge
    function automatic logic [31:0] mk(input int kind, input int data, input int off);
        logic [7:0]  k = 8'(kind);
        logic [15:0] d = 16'(data);
        logic [7:0]  o = 8'(off);
        return {k, d, o};
    endfunction

    task automatic got(input int kind, input int data);
        logic [31:0] a;
        a = mk(kind, data, cyc - t0);
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_event actual=%0h required=none", a);
        end else begin
            check("event", a, exp_q.pop_front());
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (acc_clear)           got(0, 0);
            if (load_w)              got(1, int'(w_idx));
            if (mem_we && mem_ready) got(2, int'({acc_sel, mem_addr}));
            if (done)                got(3, int'(timeout_err));
        end
    end

    task automatic push_front_half();
        exp_q.push_back(mk(0, 0, 0));
        for (int i = 0; i < 4; i++) exp_q.push_back(mk(1, i, 1 + i));
    endtask

    // fc: COMPUTE cycle (1-based) carrying acc_full, 0 = never
    task automatic push_job(input logic [7:0] base, input int fc, input int stall);
        logic [7:0] a;
        push_front_half();
        if (fc == 0) begin
            exp_q.push_back(mk(3, 1, 5 + TIMEOUT_P));
        end else begin
            for (int k = 0; k < NUM_ACC_P; k++) begin
                a = base + 8'(k);
                exp_q.push_back(mk(2, int'({2'(k), a}), 6 + fc + stall + k));
            end
            exp_q.push_back(mk(3, 0, 6 + fc + stall + NUM_ACC_P));
        end
    endtask

    task automatic issue_start(input logic [7:0] base);
        start = 1'b1;
        base_addr = base;
        @(posedge clk); #1;
        start = 1'b0;
        base_addr = 8'h5A;
        t0 = cyc;
        check("start_accept", {30'd0, busy, timeout_err}, 32'h2);
    endtask

    task automatic job(input logic [7:0] base, input int fc, input int stall, input bit poke);
        bit ok;
        issue_start(base);
        push_job(base, fc, stall);
        for (int e = 1; e <= 4 + fc; e++) begin
            @(posedge clk); #1;
            if (poke && e == 1) start = 1'b1;
            if (poke && e == 2) start = 1'b0;
        end
        if (fc > 0) begin
            acc_full = 1'b1;
            @(negedge clk);
            check("compute_valid", {31'd0, acc_valid}, 32'd1);
            @(posedge clk); #1;
            acc_full = 1'b0;
            if (stall > 0) mem_ready = 1'b0;
            @(negedge clk);
            check("settle_idle", {30'd0, acc_valid, mem_we}, 32'd0);
            for (int s = 0; s < stall; s++) begin
                @(posedge clk); #1;
                @(negedge clk);
                check("stall_hold", {21'd0, mem_we, acc_sel, mem_addr}, {21'd0, 1'b1, 2'd0, base});
            end
            if (stall > 0) begin
                @(posedge clk); #1;
                mem_ready = 1'b1;
            end
        end
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (done) begin ok = 1'b1; break; end
        end
        check("done_seen", {31'd0, ok}, 32'd1);
        if (poke) begin
            start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            repeat (4) @(posedge clk);
            #1;
            check("no_second_job", {31'd0, busy}, 32'd0);
        end else begin
            @(posedge clk); #1;
        end
    endtask

    function automatic logic [31:0] outs();
        return {11'd0, busy, done, acc_clear, load_w, w_idx, acc_valid, mem_we,
                mem_addr, acc_sel, timeout_err};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("reset_state", outs(), 32'd0);
        reset = 1'b0;
        job(8'h10, 5, 0, 1'b0);
        job(8'hFF, 5, 0, 1'b0);
        job(8'h40, 5, 3, 1'b0);
        job(8'h80, 5, 0, 1'b1);

        issue_start(8'h30);
        push_front_half();
        repeat (9) @(posedge clk);
        #1 acc_full = 1'b1;
        @(posedge clk); #1;
        acc_full = 1'b0;
        @(posedge clk); #1;
        check("mid_write", {31'd0, mem_we}, 32'd1);
        reset = 1'b1;
        #1;
        check("reset_async", outs(), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        job(8'h20, 5, 0, 1'b0);

`ifdef SEQ_TIMEOUT_EN
        job(8'h33, 0, 0, 1'b0);
        check("err_sticky", {31'd0, timeout_err}, 32'd1);
        job(8'h44, TIMEOUT_P, 0, 1'b0);
`endif
        repeat (5) @(posedge clk);
        #1;
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/compute_sequencer.md
COMPUTE_SEQUENCER -- requirements
Module: compute_sequencer

Interface
REQ-001 Parameter NUM_W, default 4, weight-load cycles per job (1..15).
REQ-002 Parameter NUM_ACC, default 2, accumulator entries drained per job (1..4).
REQ-003 Parameter TIMEOUT, default 64, max COMPUTE cycles before abort (2..255).
REQ-004 clk  input  1  clock; all state changes on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 start  input  1  job request; sampled only in IDLE.
REQ-007 base_addr  input  8  result write base address; captured on accepted start.
REQ-008 acc_full  input  1  accumulator full flag.
REQ-009 mem_ready  input  1  result memory accepts a write this cycle.
REQ-010 busy  output  1  high in every state except IDLE.
REQ-011 done  output  1  one-cycle pulse on job completion.
REQ-012 acc_clear  output  1  accumulator clear strobe.
REQ-013 load_w  output  1  weight-load enable.
REQ-014 w_idx  output  4  weight index during LOAD_W.
REQ-015 acc_valid  output  1  accumulator compute enable.
REQ-016 mem_we  output  1  result write strobe.
REQ-017 mem_addr  output  8  result write address.
REQ-018 acc_sel  output  2  accumulator entry selected for write.
REQ-019 timeout_err  output  1  sticky abort flag.

Function
REQ-020 States SHALL be IDLE, CLEAR, LOAD_W, COMPUTE, SETTLE, WRITE, DONE, registered, Moore outputs.
REQ-021 IDLE->CLEAR when start=1; start in any other state SHALL be ignored, not queued.
REQ-022 CLEAR SHALL last 1 cycle with acc_clear=1, then LOAD_W.
REQ-023 LOAD_W SHALL last exactly NUM_W cycles, load_w=1, w_idx=0..NUM_W-1 ascending, then COMPUTE.
REQ-024 COMPUTE SHALL hold acc_valid=1 continuously; on acc_full=1 go to SETTLE next cycle.
REQ-025 SETTLE SHALL last 1 cycle, acc_valid=0, covering the accumulator's registered-output delay.
REQ-026 WRITE SHALL issue NUM_ACC writes; mem_we=1 each cycle in WRITE; write k SHALL complete only on a cycle with mem_ready=1, else addr/sel hold.
REQ-027 Write k SHALL present acc_sel=k, mem_addr=(base_addr+k) mod 256 (8-bit wrap).
REQ-028 After write NUM_ACC-1 completes, go to DONE; DONE SHALL assert done=1 for 1 cycle then return to IDLE.
REQ-029 start asserted in DONE SHALL be ignored; a new job needs start in IDLE (earliest one cycle after done).
REQ-030 acc_full=1 outside COMPUTE SHALL have no effect.
REQ-031 All strobe outputs not listed for a state SHALL be 0 in that state; w_idx, acc_sel SHALL be 0 outside their states.
REQ-032 timeout_err SHALL clear on accepted start.

Reset
REQ-033 reset=1 SHALL force IDLE immediately regardless of state, abandoning any job without done.
REQ-034 Reset values: all outputs 0, counters 0, captured base_addr 0, timeout_err 0.
REQ-035 First start SHALL be accepted on the first rising edge after reset deasserts.

Configuration
REQ-036 Macro SEQ_TIMEOUT_EN: when defined, a COMPUTE cycle counter SHALL abort to DONE after TIMEOUT cycles without acc_full, setting timeout_err=1 and skipping WRITE.
REQ-037 acc_full=1 on the TIMEOUT-th cycle itself SHALL win over timeout (SETTLE, no error).
REQ-038 Without SEQ_TIMEOUT_EN, COMPUTE waits indefinitely, no counter logic exists, timeout_err tied 0.

Verification
REQ-039 Defaults, base_addr=8'h10, acc_full rises 5 cycles into COMPUTE, mem_ready=1 -> clear 1 cycle, w_idx 0,1,2,3, writes addr 10h sel0 then 11h sel1, done 13 cycles after start edge.
REQ-040 base_addr=8'hFF, NUM_ACC=2 -> writes to FFh then 00h.
REQ-041 mem_ready=0 for 3 cycles during first write -> mem_addr/acc_sel held, total latency +3, exactly 2 completed writes.
REQ-042 start pulsed in LOAD_W and DONE -> ignored; busy/done sequence unchanged, no second job.
REQ-043 reset asserted mid-WRITE -> outputs 0 same cycle, IDLE, no done; next start runs a full clean job.
REQ-044 SEQ_TIMEOUT_EN, TIMEOUT=8, acc_full never set -> 8 COMPUTE cycles, no mem_we, done pulse, timeout_err=1 until next start.
